i2c_master_arb_seq: RTL and testbench

// - Shared I2C master: arbitrates NREQ on-chip requesters for one I2C bus and sequences each granted

---
 rtl/i2c_pkg.sv | 14 +
 rtl/i2c_master_arb_seq_if.sv | 29 ++
 rtl/i2c_rr_arbiter.sv | 27 ++
 rtl/i2c_master_arb_seq.sv | 137 +++++++++++++
 tb/tb_i2c_master_arb_seq.sv | 302 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/i2c_pkg.sv
// Shared types and constants for the arbitrated single-byte I2C master.
package i2c_pkg;
  localparam int ADDR_W = 7;
  localparam int DATA_W = 8;

  typedef enum logic [2:0] {
    IDLE, START, ADDR, ADDR_ACK, DATA, DATA_ACK, STOP, DONE
  } i2c_state_t;

  localparam logic [1:0] Q0 = 2'd0;
  localparam logic [1:0] Q1 = 2'd1;
  localparam logic [1:0] Q2 = 2'd2;
  localparam logic [1:0] Q3 = 2'd3;
endpackage

// File: rtl/i2c_master_arb_seq_if.sv
// Requester handshake and open-drain pin bundle for the shared I2C master.
interface i2c_master_arb_seq_if
  import i2c_pkg::*;
#(
  parameter int NREQ = 2
);
  logic [NREQ-1:0]        req;
  logic [NREQ*ADDR_W-1:0] req_addr;
  logic [NREQ-1:0]        req_rw;
  logic [NREQ*DATA_W-1:0] req_wdata;
  logic [NREQ-1:0]        gnt;
  logic                   busy;
  logic                   done;
  logic                   ack_err;
  logic [DATA_W-1:0]      rdata;
  logic                   scl_o;
  logic                   sda_o;
  logic                   sda_i;

  // master = the shared I2C engine; slave = requesters plus the bus side
  modport master (
    input  req, req_addr, req_rw, req_wdata, sda_i,
    output gnt, busy, done, ack_err, rdata, scl_o, sda_o
  );
  modport slave (
    output req, req_addr, req_rw, req_wdata, sda_i,
    input  gnt, busy, done, ack_err, rdata, scl_o, sda_o
  );
endinterface

// File: rtl/i2c_rr_arbiter.sv
// Round-robin pick: first set request at or after rr_ptr, wrapping modulo NREQ.
module i2c_rr_arbiter #(
  parameter int NREQ = 2,
  parameter int PW   = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [PW-1:0]   rr_ptr,
  output logic [PW-1:0]   idx,
  output logic [NREQ-1:0] onehot,
  output logic            valid
);
  always_comb begin
    int j;
    valid = 1'b0;
    idx   = '0;
    j     = 0;
    // Scan farthest offset first so the nearest requester overwrites.
    for (int k = NREQ - 1; k >= 0; k--) begin
      j = (int'(rr_ptr) + k) % NREQ;
      if (req[j]) begin
        valid = 1'b1;
        idx   = PW'(j);
      end
    end
    onehot = valid ? (NREQ'(1) << idx) : '0;
  end
endmodule

// File: rtl/i2c_master_arb_seq.sv
// Shared I2C master: arbitrates requesters and sequences one START/addr/data/STOP transaction each.
module i2c_master_arb_seq
  import i2c_pkg::*;
#(
  parameter int NREQ    = 2,
  parameter int CLK_DIV = 4
) (
  input logic                  clk,
  input logic                  reset,
  i2c_master_arb_seq_if.master bus
);
  localparam int PW = $clog2(NREQ);
  localparam int QW = $clog2(CLK_DIV);

  i2c_state_t        state, state_n;
  logic [1:0]        phase;
  logic [QW-1:0]     qcnt;
  logic [2:0]        bit_cnt;
  logic [PW-1:0]     rr_ptr, win_idx, win_l;
  logic [NREQ-1:0]   win_oh, gnt_l;
  logic              win_vld;
  logic [DATA_W-1:0] tx_addr, wdata_l, rx_sh, rdata_r;
  logic              rw_l, ack_bit, err_flag, ack_err_r;
  logic              tick, slot_end, scl_hi, scl, sda;

  i2c_rr_arbiter #(.NREQ(NREQ), .PW(PW)) u_arb (
    .req    (bus.req),
    .rr_ptr (rr_ptr),
    .idx    (win_idx),
    .onehot (win_oh),
    .valid  (win_vld)
  );

  assign tick     = (state != IDLE) && (state != DONE) && (qcnt == QW'(CLK_DIV - 1));
  assign slot_end = tick && (phase == Q3);
  assign scl_hi   = (phase == Q2) || (phase == Q3);

  always_comb begin
    state_n = state;
    scl     = 1'b1;
    sda     = 1'b1;
    case (state)
      IDLE:     if (win_vld) state_n = START;
      START: begin
        sda = (phase == Q0) || (phase == Q1);
        if (slot_end) state_n = ADDR;
      end
      ADDR: begin
        scl = scl_hi;
        sda = tx_addr[~bit_cnt];
        if (slot_end && bit_cnt == 3'd7) state_n = ADDR_ACK;
      end
      ADDR_ACK: begin
        scl = scl_hi;
        if (slot_end) state_n = ack_bit ? STOP : DATA;
      end
      DATA: begin
        scl = scl_hi;
        sda = rw_l ? 1'b1 : wdata_l[~bit_cnt];
        if (slot_end && bit_cnt == 3'd7) state_n = DATA_ACK;
      end
      DATA_ACK: begin
        // Released SDA doubles as the master NACK that ends a read.
        scl = scl_hi;
        if (slot_end) state_n = STOP;
      end
      STOP: begin
        scl = (phase != Q0);
        sda = (phase == Q3);
        if (slot_end) state_n = DONE;
      end
      DONE:     state_n = IDLE;
      default:  state_n = IDLE;
    endcase
  end

  // Control state: FSM, quarter timing, arbitration pointer, result registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      phase     <= Q0;
      qcnt      <= '0;
      bit_cnt   <= '0;
      rr_ptr    <= '0;
      gnt_l     <= '0;
      err_flag  <= 1'b0;
      ack_err_r <= 1'b0;
      rdata_r   <= '0;
    end else begin
      state <= state_n;
      if (state == IDLE) begin
        phase   <= Q0;
        qcnt    <= '0;
        bit_cnt <= '0;
        if (win_vld) begin
          gnt_l    <= win_oh;
          err_flag <= 1'b0;
        end
      end else if (state == DONE) begin
        rr_ptr <= (win_l == PW'(NREQ - 1)) ? '0 : win_l + PW'(1);
      end else begin
        qcnt <= tick ? '0 : qcnt + 1'b1;
        if (tick) phase <= phase + 2'd1;
        if (slot_end && (state == ADDR || state == DATA)) bit_cnt <= bit_cnt + 3'd1;
        if (slot_end && ack_bit && (state == ADDR_ACK || (state == DATA_ACK && !rw_l)))
          err_flag <= 1'b1;
        if (slot_end && state == STOP) begin
          gnt_l     <= '0;
          ack_err_r <= err_flag;
          if (rw_l) rdata_r <= rx_sh;
        end
      end
    end
  end

  // Data capture: request latch at grant, SDA samples on the tick ending q2
  always_ff @(posedge clk) begin
    if (state == IDLE && win_vld) begin
      tx_addr <= {bus.req_addr[ADDR_W*win_idx +: ADDR_W], bus.req_rw[win_idx]};
      wdata_l <= bus.req_wdata[DATA_W*win_idx +: DATA_W];
      rw_l    <= bus.req_rw[win_idx];
      win_l   <= win_idx;
    end
    if (tick && phase == Q2) begin
      if (state == DATA) rx_sh <= {rx_sh[DATA_W-2:0], bus.sda_i};
      if (state == ADDR_ACK || state == DATA_ACK) ack_bit <= bus.sda_i;
    end
  end

  assign bus.gnt     = gnt_l;
  assign bus.busy    = (state != IDLE);
  assign bus.done    = (state == DONE);
  assign bus.ack_err = ack_err_r;
  assign bus.rdata   = rdata_r;
  assign bus.scl_o   = scl;
  assign bus.sda_o   = sda;
endmodule

// File: tb/tb_i2c_master_arb_seq.sv
// Bench for the shared I2C master: quarter-level bus model, slave responder, directed transactions.
module tb_i2c_master_arb_seq;
  import i2c_pkg::*;
  localparam int NREQ = 2;
  localparam int C    = 4;

  logic clk        = 1'b0;
  logic reset      = 1'b1;
  logic slave_pull = 1'b0;
  int   checks     = 0;
  int   errors     = 0;

  always #5 clk = ~clk;

  i2c_master_arb_seq_if #(.NREQ(NREQ)) bus ();
  assign bus.sda_i = bus.sda_o & ~slave_pull;

  i2c_master_arb_seq #(.NREQ(NREQ), .CLK_DIV(C)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      if (errors <= 40) $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Slave behaviour for the next granted transaction
  bit         cfg_aack  = 1'b1;
  bit         cfg_dack  = 1'b1;
  logic [7:0] cfg_rbyte = 8'h00;

  // Reference model: the expected pin waveform as a list of {scl,sda} quarters
  bit         m_valid = 1'b0, m_active = 1'b0, m_rst = 1'b0;
  int         m_off = 0, m_nq = 0, m_win = 0, m_rr = 0;
  bit         m_rw, m_aack, m_dack, m_err;
  logic [7:0] m_rbyte;
  logic [1:0] m_q[$];

  function automatic void push_slot(input logic b);
    m_q.push_back({1'b0, b});
    m_q.push_back({1'b0, b});
    m_q.push_back({1'b1, b});
    m_q.push_back({1'b1, b});
  endfunction

  always @(negedge clk) begin
    logic [NREQ-1:0] e_gnt;
    logic            e_busy, e_done;
    logic [1:0]      e_bus;
    logic [7:0]      ab, wd;
    int              slot;
    bit              found;
    if (m_valid) begin
      if (m_active && m_off < m_nq * C) begin
        e_gnt = NREQ'(1) << m_win; e_busy = 1'b1; e_done = 1'b0; e_bus = m_q[m_off / C];
      end else if (m_active) begin
        e_gnt = '0; e_busy = 1'b1; e_done = 1'b1; e_bus = 2'b11;
      end else begin
        e_gnt = '0; e_busy = 1'b0; e_done = 1'b0; e_bus = 2'b11;
      end
      chk("gnt", 32'(bus.gnt), 32'(e_gnt));
      chk("busy", bus.busy, e_busy);
      chk("done", bus.done, e_done);
      chk("scl_o", bus.scl_o, e_bus[1]);
      chk("sda_o", bus.sda_o, e_bus[0]);
      if (m_active && m_off == m_nq * C) begin
        chk("ack_err", bus.ack_err, m_err);
        if (m_rw) chk("rdata", bus.rdata, m_rbyte);
      end
      if (m_rst) begin
        chk("rst_rdata", bus.rdata, 0);
        chk("rst_ack_err", bus.ack_err, 0);
      end
    end

    slave_pull = 1'b0;
    if (m_active && m_off < m_nq * C && m_off / C >= 4) begin
      slot = (m_off / C - 4) / 4;
      if (slot == 8) slave_pull = m_aack;
      else if (m_aack && m_rw && slot >= 9 && slot <= 16) slave_pull = !m_rbyte[16 - slot];
      else if (m_aack && !m_rw && slot == 17) slave_pull = m_dack;
    end

    if (reset) begin
      m_valid = 1'b1; m_active = 1'b0; m_rr = 0; m_rst = 1'b1;
    end else begin
      m_rst = 1'b0;
      if (m_active) begin
        if (m_off == m_nq * C) begin
          m_active = 1'b0;
          m_rr     = (m_win + 1) % NREQ;
        end else begin
          m_off++;
        end
      end else if (m_valid && bus.req != '0) begin
        found = 1'b0;
        for (int k = 0; k < NREQ; k++)
          if (!found && bus.req[(m_rr + k) % NREQ]) begin
            found = 1'b1;
            m_win = (m_rr + k) % NREQ;
          end
        m_rw    = bus.req_rw[m_win];
        ab      = {bus.req_addr[7*m_win +: 7], m_rw};
        wd      = bus.req_wdata[8*m_win +: 8];
        m_aack  = cfg_aack;
        m_dack  = cfg_dack;
        m_rbyte = cfg_rbyte;
        m_q.delete();
        m_q.push_back(2'b11); m_q.push_back(2'b11); m_q.push_back(2'b10); m_q.push_back(2'b10);
        for (int b = 7; b >= 0; b--) push_slot(ab[b]);
        push_slot(1'b1);
        if (m_aack) begin
          for (int b = 7; b >= 0; b--) push_slot(m_rw ? 1'b1 : wd[b]);
          push_slot(1'b1);
        end
        m_q.push_back(2'b00); m_q.push_back(2'b10); m_q.push_back(2'b10); m_q.push_back(2'b11);
        m_err    = !m_aack || (!m_rw && !m_dack);
        m_nq     = m_q.size();
        m_active = 1'b1;
        m_off    = 0;
      end
    end
  end

  // Observation of the pins for the directed literal checks
  int              mcyc = 0, done_cnt = 0, done_cyc = 0, gnt_rise_cyc = 0;
  logic            done_err;
  logic [7:0]      done_rdata;
  logic [NREQ-1:0] prev_gnt = '0;
  logic            prev_scl = 1'b1;
  logic [NREQ-1:0] gnt_hist[$];
  logic            bits[$];

  always @(negedge clk) begin
    if (bus.gnt != '0 && prev_gnt == '0) begin
      gnt_rise_cyc = mcyc;
      gnt_hist.push_back(bus.gnt);
    end
    if (bus.done === 1'b1) begin
      done_cnt++;
      done_cyc   = mcyc;
      done_err   = bus.ack_err;
      done_rdata = bus.rdata;
    end
    if (bus.scl_o && !prev_scl && bus.gnt != '0) bits.push_back(bus.sda_i);
    prev_gnt = bus.gnt;
    prev_scl = bus.scl_o;
    mcyc++;
  end

  function automatic logic [7:0] pack(input int off);
    logic [7:0] v = 'x;
    if (bits.size() >= off + 8)
      for (int i = 0; i < 8; i++) v = {v[6:0], bits[off + i]};
    return v;
  endfunction

  function automatic logic getbit(input int i);
    return (i < bits.size()) ? bits[i] : 1'bx;
  endfunction

  function automatic logic [NREQ-1:0] hist(input int i);
    return (i < gnt_hist.size()) ? gnt_hist[i] : 'x;
  endfunction

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic run_txn(input int w, input logic [6:0] a, input logic rw, input logic [7:0] wd,
                         input bit aack, input bit dack, input logic [7:0] rb, input bit drop,
                         output int lat);
    int d0;
    d0        = done_cnt;
    cfg_aack  = aack;
    cfg_dack  = dack;
    cfg_rbyte = rb;
    bus.req_addr[7*w +: 7]  = a;
    bus.req_rw[w]           = rw;
    bus.req_wdata[8*w +: 8] = wd;
    bits.delete();
    bus.req[w] = 1'b1;
    for (int i = 0; i < 1000 && done_cnt == d0; i++) begin
      step(1);
      if (drop && bus.gnt != '0) bus.req[w] = 1'b0;
    end
    bus.req[w] = 1'b0;
    chk("txn_done_seen", done_cnt != d0, 1);
    lat = done_cyc - gnt_rise_cyc;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat, d0;
    bus.req = '0; bus.req_addr = '0; bus.req_rw = '0; bus.req_wdata = '0;
    reset = 1'b1;
    step(3);
    chk("reset_scl", bus.scl_o, 1);
    chk("reset_sda", bus.sda_o, 1);
    chk("reset_gnt", 32'(bus.gnt), 0);
    chk("reset_busy", bus.busy, 0);
    chk("reset_done", bus.done, 0);
    chk("reset_rdata", bus.rdata, 0);
    chk("reset_ack_err", bus.ack_err, 0);
    reset = 1'b0;
    step(2);

    run_txn(0, 7'h50, 1'b0, 8'hA5, 1, 1, 8'h00, 0, lat);
    chk("wr_latency", lat, 320);
    chk("wr_ack_err", done_err, 0);
    chk("wr_nbits", bits.size(), 19);
    chk("wr_addr_byte", pack(0), 8'hA0);
    chk("wr_addr_ack", getbit(8), 0);
    chk("wr_data_byte", pack(9), 8'hA5);
    chk("wr_data_ack", getbit(17), 0);

    run_txn(1, 7'h3C, 1'b1, 8'h00, 1, 1, 8'h5A, 0, lat);
    chk("rd_latency", lat, 320);
    chk("rd_rdata", done_rdata, 8'h5A);
    chk("rd_ack_err", done_err, 0);
    chk("rd_addr_byte", pack(0), 8'h79);
    chk("rd_addr_ack", getbit(8), 0);
    chk("rd_data_byte", pack(9), 8'h5A);
    chk("rd_master_nack", getbit(17), 1);

    run_txn(0, 7'h21, 1'b0, 8'h33, 0, 1, 8'h00, 0, lat);
    chk("nack_latency", lat, 176);
    chk("nack_ack_err", done_err, 1);
    chk("nack_nbits", bits.size(), 10);
    chk("nack_addr_byte", pack(0), 8'h42);

    run_txn(1, 7'h11, 1'b0, 8'hFF, 1, 0, 8'h00, 0, lat);
    chk("dnack_latency", lat, 320);
    chk("dnack_ack_err", done_err, 1);
    chk("dnack_bit", getbit(17), 1);

    bus.req_addr  = {7'h12, 7'h34};
    bus.req_rw    = 2'b00;
    bus.req_wdata = {8'hC3, 8'h3C};
    cfg_aack = 1; cfg_dack = 1;
    gnt_hist.delete();
    d0 = done_cnt;
    bus.req = 2'b11;
    for (int i = 0; i < 3000 && done_cnt < d0 + 4; i++) step(1);
    bus.req = '0;
    chk("cont_dones", done_cnt - d0, 4);
    chk("cont_gnt0", 32'(hist(0)), 1);
    chk("cont_gnt1", 32'(hist(1)), 2);
    chk("cont_gnt2", 32'(hist(2)), 1);
    chk("cont_gnt3", 32'(hist(3)), 2);
    step(3);

    run_txn(0, 7'h55, 1'b0, 8'h0F, 1, 1, 8'h00, 0, lat);
    chk("pre_rst_latency", lat, 320);

    bus.req_addr[13:7] = 7'h6B;
    bus.req_rw[1]      = 1'b0;
    bus.req[1]         = 1'b1;
    for (int i = 0; i < 20 && bus.gnt == '0; i++) step(1);
    chk("rm_gnt", 32'(bus.gnt), 2);
    step(4*C + 3*4*C + C);
    chk("rm_busy_before", bus.busy, 1);
    reset = 1'b1;
    step(1);
    chk("rm_scl", bus.scl_o, 1);
    chk("rm_sda", bus.sda_o, 1);
    chk("rm_gnt_after", 32'(bus.gnt), 0);
    chk("rm_busy_after", bus.busy, 0);
    bus.req = '0;
    step(1);
    reset = 1'b0;
    step(2);

    gnt_hist.delete();
    d0 = done_cnt;
    bus.req = 2'b11;
    for (int i = 0; i < 1000 && done_cnt == d0; i++) step(1);
    bus.req = '0;
    chk("rm_rr_first_gnt", 32'(hist(0)), 1);
    step(3);

    run_txn(0, 7'h0A, 1'b0, 8'h81, 1, 1, 8'h00, 1, lat);
    chk("drop_latency", lat, 320);
    chk("drop_ack_err", done_err, 0);
    chk("drop_stop_bit", getbit(18), 0);

    step(5);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
